// File: rtl/axi_to_simple_axi.sv
// AXI4 slave to simple valid/ready bridge.
// Write and read paths are independent FSMs. Writes stream through at one beat
// per cycle. Reads issue one simple request per beat, and each response is
// buffered before it is returned on the R channel.
module axi_to_simple_axi #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // AXI write address
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    // AXI write data
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    // AXI write response
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    // AXI read address
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    // AXI read data
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    // simple write port
    output logic                    s_wvalid_o,
    input  logic                    s_wready_i,
    output logic [AXI_ADDR_W-1:0]   s_waddr_o,
    output logic [AXI_DATA_W-1:0]   s_wdata_o,
    output logic [AXI_DATA_W/8-1:0] s_wstrb_o,
    output logic                    s_wlast_o,
    // simple read port
    output logic                    s_rvalid_o,
    input  logic                    s_rready_i,
    output logic [AXI_ADDR_W-1:0]   s_raddr_o,
    input  logic [AXI_DATA_W-1:0]   s_rdata_i,
    input  logic                    s_rdvalid_i
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam logic [AXI_ADDR_W-1:0] BEAT_BYTES = AXI_ADDR_W'(AXI_DATA_W / 8);
    localparam logic [AXI_LEN_W-1:0]  LEN_ONE    = AXI_LEN_W'(1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2,
        R_DATA = 2'd3
    } r_state_t;

    w_state_t w_state_r, w_state_s;
    r_state_t r_state_r, r_state_s;

    logic [AXI_ID_W-1:0]   wid_r;
    logic [AXI_ADDR_W-1:0] waddr_r;
    logic [AXI_LEN_W-1:0]  wlen_r;
    logic [AXI_LEN_W-1:0]  wcnt_r;
    logic                  werr_r;

    logic [AXI_ID_W-1:0]   rid_r;
    logic [AXI_ADDR_W-1:0] raddr_r;
    logic [AXI_LEN_W-1:0]  rlen_r;
    logic [AXI_LEN_W-1:0]  rcnt_r;
    logic [AXI_DATA_W-1:0] rbuf_r;

    logic aw_hs_s;
    logic w_beat_s;
    logic w_final_s;
    logic ar_hs_s;
    logic r_final_s;

    // Size and burst type are fixed by construction; they are only sunk here.
    logic unused_s;
    assign unused_s = ^{axi_awsize_i, axi_awburst_i, axi_arsize_i, axi_arburst_i};

    assign aw_hs_s   = (w_state_r == W_IDLE) && axi_awvalid_i;
    assign w_beat_s  = (w_state_r == W_DATA) && axi_wvalid_i && s_wready_i;
    assign w_final_s = (wcnt_r == wlen_r);
    assign ar_hs_s   = (r_state_r == R_IDLE) && axi_arvalid_i;
    assign r_final_s = (rcnt_r == rlen_r);

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_s;
        end
    end

    // Write FSM next-state decode.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (axi_awvalid_i) w_state_s = W_DATA;
                else               w_state_s = W_IDLE;
            end
            W_DATA: begin
                if (w_beat_s && w_final_s) w_state_s = W_RESP;
                else                       w_state_s = W_DATA;
            end
            W_RESP: begin
                if (axi_bready_i) w_state_s = W_IDLE;
                else              w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write burst context: captured on AW, advanced on every forwarded beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wid_r   <= {AXI_ID_W{1'b0}};
            waddr_r <= {AXI_ADDR_W{1'b0}};
            wlen_r  <= {AXI_LEN_W{1'b0}};
            wcnt_r  <= {AXI_LEN_W{1'b0}};
            werr_r  <= 1'b0;
        end else if (aw_hs_s) begin
            wid_r   <= axi_awid_i;
            waddr_r <= axi_awaddr_i;
            wlen_r  <= axi_awlen_i;
            wcnt_r  <= {AXI_LEN_W{1'b0}};
            werr_r  <= 1'b0;
        end else if (w_beat_s) begin
            waddr_r <= waddr_r + BEAT_BYTES;
            wcnt_r  <= wcnt_r + LEN_ONE;
            if (axi_wlast_i != w_final_s) begin
                werr_r <= 1'b1;
            end
        end
    end

    // Write channel outputs; W data is gated so nothing leaks outside a burst.
    assign axi_awready_o = (w_state_r == W_IDLE);
    assign axi_wready_o  = (w_state_r == W_DATA) && s_wready_i;
    assign s_wvalid_o    = (w_state_r == W_DATA) && axi_wvalid_i;
    assign s_waddr_o     = waddr_r;
    assign s_wdata_o     = (w_state_r == W_DATA) ? axi_wdata_i : {AXI_DATA_W{1'b0}};
    assign s_wstrb_o     = (w_state_r == W_DATA) ? axi_wstrb_i : {STRB_W{1'b0}};
    assign s_wlast_o     = (w_state_r == W_DATA) && w_final_s;
    assign axi_bvalid_o  = (w_state_r == W_RESP);
    assign axi_bid_o     = wid_r;
    assign axi_bresp_o   = ((w_state_r == W_RESP) && werr_r) ? 2'b10 : 2'b00;

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_s;
        end
    end

    // Read FSM next-state decode.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (axi_arvalid_i) r_state_s = R_REQ;
                else               r_state_s = R_IDLE;
            end
            R_REQ: begin
                if (s_rready_i) r_state_s = R_WAIT;
                else            r_state_s = R_REQ;
            end
            R_WAIT: begin
                if (s_rdvalid_i) r_state_s = R_DATA;
                else             r_state_s = R_WAIT;
            end
            R_DATA: begin
                if (axi_rready_i && r_final_s)  r_state_s = R_IDLE;
                else if (axi_rready_i)          r_state_s = R_REQ;
                else                            r_state_s = R_DATA;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read burst context and response buffer; responses outside R_WAIT are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rid_r   <= {AXI_ID_W{1'b0}};
            raddr_r <= {AXI_ADDR_W{1'b0}};
            rlen_r  <= {AXI_LEN_W{1'b0}};
            rcnt_r  <= {AXI_LEN_W{1'b0}};
            rbuf_r  <= {AXI_DATA_W{1'b0}};
        end else begin
            if (ar_hs_s) begin
                rid_r   <= axi_arid_i;
                raddr_r <= axi_araddr_i;
                rlen_r  <= axi_arlen_i;
                rcnt_r  <= {AXI_LEN_W{1'b0}};
            end else if ((r_state_r == R_DATA) && axi_rready_i && !r_final_s) begin
                raddr_r <= raddr_r + BEAT_BYTES;
                rcnt_r  <= rcnt_r + LEN_ONE;
            end
            if ((r_state_r == R_WAIT) && s_rdvalid_i) begin
                rbuf_r <= s_rdata_i;
            end
        end
    end

    // Read channel outputs, decoded from state and registers only.
    assign axi_arready_o = (r_state_r == R_IDLE);
    assign s_rvalid_o    = (r_state_r == R_REQ);
    assign s_raddr_o     = raddr_r;
    assign axi_rvalid_o  = (r_state_r == R_DATA);
    assign axi_rid_o     = rid_r;
    assign axi_rdata_o   = rbuf_r;
    assign axi_rresp_o   = 2'b00;
    assign axi_rlast_o   = (r_state_r == R_DATA) && r_final_s;

endmodule

// File: tb/tb_axi_to_simple_axi.sv
// Scoreboard bench for axi_to_simple_axi: tasks push expected simple beats,
// B and R responses into queues, and a negedge monitor pops and compares them.
module tb_axi_to_simple_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  axi_awid_i;
    logic [31:0] axi_awaddr_i;
    logic [7:0]  axi_awlen_i;
    logic [2:0]  axi_awsize_i;
    logic [1:0]  axi_awburst_i;
    logic        axi_awvalid_i;
    logic        axi_awready_o;
    logic [31:0] axi_wdata_i;
    logic [3:0]  axi_wstrb_i;
    logic        axi_wlast_i;
    logic        axi_wvalid_i;
    logic        axi_wready_o;
    logic [3:0]  axi_bid_o;
    logic [1:0]  axi_bresp_o;
    logic        axi_bvalid_o;
    logic        axi_bready_i;
    logic [3:0]  axi_arid_i;
    logic [31:0] axi_araddr_i;
    logic [7:0]  axi_arlen_i;
    logic [2:0]  axi_arsize_i;
    logic [1:0]  axi_arburst_i;
    logic        axi_arvalid_i;
    logic        axi_arready_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic        axi_rlast_o;
    logic        axi_rvalid_o;
    logic        axi_rready_i;
    logic        s_wvalid_o;
    logic        s_wready_i;
    logic [31:0] s_waddr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic        s_wlast_o;
    logic        s_rvalid_o;
    logic        s_rready_i;
    logic [31:0] s_raddr_o;
    logic [31:0] s_rdata_i;
    logic        s_rdvalid_i;

    axi_to_simple_axi dut (
        .clk_i(clk), .rst_i(rst),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awsize_i(axi_awsize_i), .axi_awburst_i(axi_awburst_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arsize_i(axi_arsize_i), .axi_arburst_i(axi_arburst_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i), .s_waddr_o(s_waddr_o),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_raddr_o(s_raddr_o),
        .s_rdata_i(s_rdata_i), .s_rdvalid_i(s_rdvalid_i)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic last;} sw_t;
    typedef struct {logic [3:0] id; logic [1:0] resp;} b_t;
    typedef struct {logic [3:0] id; logic [31:0] data; logic last;} r_t;

    sw_t ws_q[$];
    b_t  b_q[$];
    r_t  r_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // simple memory model and flow-control knobs
    logic        mem_hs = 1'b0;
    logic [31:0] mem_hs_addr = 32'h0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt = 0;
    logic        wtoggle = 1'b0;
    int          stall_left = 0;
    int          tb_rbeat = 0;
    time         t_aw_hs = 0;
    time         t_ar_hs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every output handshake pops the matching expectation.
    initial begin
        sw_t e; b_t eb; r_t er;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_wvalid_o && s_wready_i) begin
                    if (ws_q.size() == 0) chk("s_w_unexpected", 64'd1, 64'd0);
                    else begin
                        e = ws_q.pop_front();
                        chk("s_waddr", {32'h0, s_waddr_o}, {32'h0, e.addr});
                        chk("s_wdata", {32'h0, s_wdata_o}, {32'h0, e.data});
                        chk("s_wstrb", {60'h0, s_wstrb_o}, {60'h0, e.strb});
                        chk("s_wlast", {63'h0, s_wlast_o}, {63'h0, e.last});
                    end
                end
                if (axi_bvalid_o && axi_bready_i) begin
                    if (b_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                    else begin
                        eb = b_q.pop_front();
                        chk("bid", {60'h0, axi_bid_o}, {60'h0, eb.id});
                        chk("bresp", {62'h0, axi_bresp_o}, {62'h0, eb.resp});
                    end
                end
                if (axi_rvalid_o && axi_rready_i) begin
                    if (r_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                    else begin
                        er = r_q.pop_front();
                        chk("rid", {60'h0, axi_rid_o}, {60'h0, er.id});
                        chk("rdata", {32'h0, axi_rdata_o}, {32'h0, er.data});
                        chk("rlast", {63'h0, axi_rlast_o}, {63'h0, er.last});
                        chk("rresp", {62'h0, axi_rresp_o}, 64'd0);
                    end
                    tb_rbeat++;
                end
                if (s_rvalid_o && s_rready_i) begin
                    mem_hs      = 1'b1;
                    mem_hs_addr = s_raddr_o;
                end
            end
        end
    end

    // Memory responder (data = addr>>2, two cycles after acceptance) and ready drivers.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            s_rdvalid_i = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    s_rdvalid_i = 1'b1;
                    s_rdata_i   = mem_addr >> 2;
                end
            end
            if (mem_hs) begin
                mem_hs   = 1'b0;
                mem_cnt  = 2;
                mem_addr = mem_hs_addr;
            end
            if (wtoggle) s_wready_i = ~s_wready_i;
            else         s_wready_i = 1'b1;
            if (axi_rvalid_o && stall_left > 0 && tb_rbeat == 2) begin
                axi_rready_i = 1'b0;
                stall_left--;
            end else begin
                axi_rready_i = 1'b1;
            end
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] dbase, input int bad_beat, input int nsend);
        logic hs;
        int   n;
        logic [31:0] a;
        a = addr;
        for (int i = 0; i < nsend; i++) begin
            ws_q.push_back('{addr: a, data: dbase + 32'(i), strb: 4'(i + 5), last: (i == int'(len))});
            a = a + 32'd4;
        end
        if (nsend == int'(len) + 1)
            b_q.push_back('{id: id, resp: (bad_beat >= 0) ? 2'b10 : 2'b00});
        axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = len; axi_awvalid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk); hs = axi_awready_o;
            @(posedge clk); if (hs) t_aw_hs = $time;
            #1; n++;
        end while (!hs && n < 50);
        if (!hs) chk("aw_timeout", 64'd0, 64'd1);
        axi_awvalid_i = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            axi_wvalid_i = 1'b1;
            axi_wdata_i  = dbase + 32'(i);
            axi_wstrb_i  = 4'(i + 5);
            axi_wlast_i  = (i == int'(len)) ^ (i == bad_beat);
            n = 0;
            do begin
                @(negedge clk); hs = axi_wready_o;
                @(posedge clk); #1; n++;
            end while (!hs && n < 50);
            if (!hs) chk("w_timeout", 64'd0, 64'd1);
        end
        axi_wvalid_i = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] dbase);
        logic hs;
        int   n;
        for (int i = 0; i <= int'(len); i++)
            r_q.push_back('{id: id, data: dbase + 32'(i), last: (i == int'(len))});
        axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = len; axi_arvalid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk); hs = axi_arready_o;
            @(posedge clk); if (hs) t_ar_hs = $time;
            #1; n++;
        end while (!hs && n < 50);
        if (!hs) chk("ar_timeout", 64'd0, 64'd1);
        axi_arvalid_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((ws_q.size() + b_q.size() + r_q.size()) != 0 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk(nm, 64'(ws_q.size() + b_q.size() + r_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        axi_awid_i = 4'h0; axi_awaddr_i = 32'h0; axi_awlen_i = 8'h0;
        axi_awsize_i = 3'd2; axi_awburst_i = 2'b01; axi_awvalid_i = 1'b0;
        axi_wdata_i = 32'h0; axi_wstrb_i = 4'h0; axi_wlast_i = 1'b0; axi_wvalid_i = 1'b0;
        axi_bready_i = 1'b1;
        axi_arid_i = 4'h0; axi_araddr_i = 32'h0; axi_arlen_i = 8'h0;
        axi_arsize_i = 3'd2; axi_arburst_i = 2'b01; axi_arvalid_i = 1'b0;
        axi_rready_i = 1'b1;
        s_wready_i = 1'b1; s_rready_i = 1'b1; s_rdata_i = 32'h0; s_rdvalid_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", {63'h0, axi_awready_o}, 64'd1);
        chk("rst_arready", {63'h0, axi_arready_o}, 64'd1);
        chk("rst_valids", {60'h0, axi_bvalid_o, axi_rvalid_o, s_wvalid_o, s_rvalid_o}, 64'd0);
        chk("rst_zeros", {32'h0, 2'b0, axi_bresp_o, axi_rresp_o, axi_rlast_o, axi_bid_o, axi_rid_o, 17'h0},
            64'd0);
        chk("rst_data", {axi_rdata_o, s_waddr_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // single write
        do_write(4'h3, 32'h0000_0100, 8'd0, 32'hDEAD_BEEF, -1, 1);
        drain("single_write_drain");

        // 4-beat write with toggling simple backpressure
        wtoggle = 1'b1;
        do_write(4'h7, 32'h0000_0200, 8'd3, 32'hA000_0000, -1, 4);
        drain("burst_write_drain");
        wtoggle = 1'b0;

        // wlast asserted early on beat 0 of a 2-beat burst
        do_write(4'h9, 32'h0000_0280, 8'd1, 32'hB000_0000, 0, 2);
        drain("wlast_err_drain");

        // address wrap at the top of the address space
        do_write(4'h1, 32'hFFFF_FFFC, 8'd1, 32'hC000_0000, -1, 2);
        drain("wrap_drain");

        // 4-beat read with a 3-cycle rready stall on beat 2
        tb_rbeat = 0; stall_left = 3;
        do_read(4'hA, 32'h0000_0040, 8'd3, 32'h0000_0010);
        drain("burst_read_drain");
        chk("rstall_used", 64'(stall_left), 64'd0);

        // AW and AR together: both accepted on the same edge
        fork
            do_write(4'h5, 32'h0000_0300, 8'd1, 32'hD000_0000, -1, 2);
            do_read(4'h6, 32'h0000_0080, 8'd1, 32'h0000_0020);
        join
        chk("same_cycle_accept", 64'(t_aw_hs), 64'(t_ar_hs));
        drain("concurrent_drain");

        // 8-beat write cut by reset after four beats; no B expected
        do_write(4'hC, 32'h0000_0500, 8'd7, 32'hE000_0000, -1, 4);
        axi_wvalid_i = 1'b1; axi_wdata_i = 32'hFFFF_FFFF; axi_wstrb_i = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_awready", {63'h0, axi_awready_o}, 64'd1);
        chk("mid_rst_valids", {61'h0, axi_bvalid_o, s_wvalid_o, axi_wready_o}, 64'd0);
        chk("mid_rst_wbeat", {s_wdata_o, s_waddr_o}, 64'd0);
        chk("mid_rst_misc", {59'h0, s_wstrb_o, s_wlast_o}, 64'd0);
        @(posedge clk); #1;
        axi_wvalid_i = 1'b0;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        do_write(4'h2, 32'h0000_0600, 8'd0, 32'h1234_5678, -1, 1);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
